// File: rtl/led_pattern_pkg.sv
// Shared types and helpers for the multi-channel LED pattern generator.
// Mode encoding is fixed so software can write raw 2-bit codes.
package led_pattern_pkg;

    localparam int MODE_W = 2;

    typedef enum logic [MODE_W-1:0] {
        MODE_OFF     = 2'd0,
        MODE_ON      = 2'd1,
        MODE_BLINK   = 2'd2,
        MODE_BREATHE = 2'd3
    } mode_e;

    localparam mode_e RESET_MODE = MODE_OFF;

    // A single channel still needs a one-bit select field.
    function automatic int chWidth(input int numCh);
        return (numCh > 1) ? $clog2(numCh) : 1;
    endfunction

endpackage

// File: rtl/led_pattern_gen_if.sv
// Configuration write port: valid/ready handshake carrying channel, mode and period.
interface led_pattern_gen_if
    import led_pattern_pkg::*;
#(
    parameter int CH_W     = 2,
    parameter int PERIOD_W = 16
) ();

    logic                cfg_valid;
    logic                cfg_ready;
    logic [CH_W-1:0]     cfg_ch;
    mode_e               cfg_mode;
    logic [PERIOD_W-1:0] cfg_period;

    modport master (
        output cfg_valid,
        output cfg_ch,
        output cfg_mode,
        output cfg_period,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid,
        input  cfg_ch,
        input  cfg_mode,
        input  cfg_period,
        output cfg_ready
    );

endinterface

// File: rtl/led_pattern_gen_channel.sv
// One LED channel: step counter on the shared tick, blink phase, breathe ramp
// and the combinational drive decision (registered by the top level).
module led_channel
    import led_pattern_pkg::*;
#(
    parameter int PERIOD_W = 16,
    parameter int PWM_W    = 8
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                tick_i,
    input  logic [PWM_W-1:0]    pwm_cnt_i,
    input  logic                load_i,
    input  mode_e               mode_i,
    input  logic [PERIOD_W-1:0] period_i,
    output logic                led_o
);

    localparam logic [PWM_W-1:0] LMAX = '1;

    mode_e               mode_q, mode_d;
    logic [PERIOD_W-1:0] period_q, period_d;
    logic [PERIOD_W-1:0] stepCnt_q, stepCnt_d;
    logic                phase_q, phase_d;
    logic [PWM_W-1:0]    level_q, level_d;
    logic                dirUp_q, dirUp_d;

    logic [PERIOD_W-1:0] stepLast;
    logic                stepEvent;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mode_q    <= RESET_MODE;
            period_q  <= PERIOD_W'(1);
            stepCnt_q <= '0;
            phase_q   <= 1'b1;
            level_q   <= '0;
            dirUp_q   <= 1'b1;
        end else begin
            mode_q    <= mode_d;
            period_q  <= period_d;
            stepCnt_q <= stepCnt_d;
            phase_q   <= phase_d;
            level_q   <= level_d;
            dirUp_q   <= dirUp_d;
        end
    end

    // A load restarts the channel and swallows any event landing on the same edge.
    always_comb begin
        mode_d    = mode_q;
        period_d  = period_q;
        stepCnt_d = stepCnt_q;
        phase_d   = phase_q;
        level_d   = level_q;
        dirUp_d   = dirUp_q;
        stepEvent = 1'b0;
        stepLast  = (period_q == '0) ? '0 : period_q - PERIOD_W'(1);

        if (load_i) begin
            mode_d    = mode_i;
            period_d  = period_i;
            stepCnt_d = '0;
            phase_d   = 1'b1;
            level_d   = '0;
            dirUp_d   = 1'b1;
        end else if (tick_i) begin
            if (stepCnt_q == stepLast) begin
                stepCnt_d = '0;
                stepEvent = 1'b1;
            end else begin
                stepCnt_d = stepCnt_q + PERIOD_W'(1);
            end
        end

        if (stepEvent && mode_q == MODE_BLINK) begin
            phase_d = ~phase_q;
        end

        // Triangle ramp reverses on the endpoint itself, so neither end dwells.
        if (stepEvent && mode_q == MODE_BREATHE) begin
            if (dirUp_q) begin
                if (level_q == LMAX) begin
                    dirUp_d = 1'b0;
                    level_d = LMAX - PWM_W'(1);
                end else begin
                    level_d = level_q + PWM_W'(1);
                end
            end else begin
                if (level_q == '0) begin
                    dirUp_d = 1'b1;
                    level_d = PWM_W'(1);
                end else begin
                    level_d = level_q - PWM_W'(1);
                end
            end
        end
    end

    always_comb begin
        led_o = 1'b0;
        case (mode_q)
            MODE_OFF:     led_o = 1'b0;
            MODE_ON:      led_o = 1'b1;
            MODE_BLINK:   led_o = phase_q;
            MODE_BREATHE: led_o = (pwm_cnt_i < level_q);
            default:      led_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/led_pattern_gen.sv
// Multi-channel LED pattern generator: shared prescaler tick and PWM counter,
// config handshake and per-channel decode feeding NUM_CH led_channel instances.
module led_pattern_gen
    import led_pattern_pkg::*;
#(
    parameter int CLK_HZ   = 100_000_000,
    parameter int TICK_HZ  = 1_000,
    parameter int NUM_CH   = 4,
    parameter int PERIOD_W = 16,
    parameter int PWM_W    = 8
) (
    input  logic               clk_i,
    input  logic               rst_i,
    led_pattern_gen_if.slave   cfg,
    output logic [NUM_CH-1:0]  led_o,
    output logic               tick_o
);

    localparam int DIV     = CLK_HZ / TICK_HZ;
    localparam int PRESC_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int CH_W    = chWidth(NUM_CH);

    if (DIV < 2 || (CLK_HZ % TICK_HZ) != 0 || NUM_CH < 1) begin : g_badParams
        $error("led_pattern_gen: CLK_HZ/TICK_HZ must be an integer >= 2 and NUM_CH >= 1");
    end

    logic [PRESC_W-1:0] presc_q, presc_d;
    logic               tick_q, tick_d;
    logic [PWM_W-1:0]   pwm_q, pwm_d;
    logic               ready_q;
    logic [NUM_CH-1:0]  led_q;

    logic               accept;
    logic [NUM_CH-1:0]  chLoad;
    logic [NUM_CH-1:0]  chLed;

    always_comb begin
        presc_d = (presc_q == PRESC_W'(DIV - 1)) ? '0 : presc_q + PRESC_W'(1);
        tick_d  = (presc_q == PRESC_W'(DIV - 1));
        pwm_d   = pwm_q + PWM_W'(1);
    end

    // Ready is simply a delayed ~reset: no back-pressure once out of reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            presc_q <= '0;
            tick_q  <= 1'b0;
            pwm_q   <= '0;
            ready_q <= 1'b0;
            led_q   <= '0;
        end else begin
            presc_q <= presc_d;
            tick_q  <= tick_d;
            pwm_q   <= pwm_d;
            ready_q <= 1'b1;
            led_q   <= chLed;
        end
    end

    assign accept        = cfg.cfg_valid && ready_q;
    assign cfg.cfg_ready = ready_q;
    assign tick_o        = tick_q;
    assign led_o         = led_q;

    // Out-of-range channel numbers match no instance, so the write is a no-op.
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        assign chLoad[i] = accept && (cfg.cfg_ch == CH_W'(i));

        led_channel #(
            .PERIOD_W (PERIOD_W),
            .PWM_W    (PWM_W)
        ) u_channel (
            .clk_i     (clk_i),
            .rst_i     (rst_i),
            .tick_i    (tick_q),
            .pwm_cnt_i (pwm_q),
            .load_i    (chLoad[i]),
            .mode_i    (cfg.cfg_mode),
            .period_i  (cfg.cfg_period),
            .led_o     (chLed[i])
        );
    end

endmodule
